// File: rtl/fp2int_pkg.sv
// fp2int_pkg: shared constants and types for the fp_to_int scheduler.
//   Float format (13 bit): [12] sign, [11:8] unsigned exponent e, [7:0] fraction m,
//   value = (-1)^s * 0.m * 2^e. Integer result is 8-bit two's complement.
package fp2int_pkg;

   localparam int FP_W     = 13;
   localparam int INT_W    = 8;

   localparam int SIGN_BIT = 12;
   localparam int EXP_MSB  = 11;
   localparam int EXP_LSB  = 8;
   localparam int MAN_MSB  = 7;
   localparam int MAN_LSB  = 0;

   localparam int EXP_W    = EXP_MSB - EXP_LSB + 1;
   localparam int MAN_W    = MAN_MSB - MAN_LSB + 1;

   localparam int INT_MAX  = 127;
   localparam int INT_MIN  = -128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      OUT  = 2'd2
   } state_t;

endpackage

// File: rtl/fp_to_int.sv
// fp_to_int: combinational float-to-integer converter.
//   i_fp  : 13-bit float operand
//   o_int : truncated (toward zero), saturated two's-complement result
//   uf    : non-zero fraction whose magnitude truncates to 0
//   of    : result outside [INT_MIN, INT_MAX], o_int saturated
module fp_to_int
   import fp2int_pkg::*;
(
   input  logic [FP_W-1:0]  i_fp,
   output logic [INT_W-1:0] o_int,
   output logic             uf,
   output logic             of
);

   // Widest possible magnitude: fraction shifted by the largest exponent.
   localparam int SH_W  = MAN_W + (1 << EXP_W) - 1;
   localparam int MAG_W = SH_W - MAN_W;

   logic             sign;
   logic [EXP_W-1:0] expo;
   logic [MAN_W-1:0] man;
   logic [MAG_W-1:0] mag;

   assign sign = i_fp[SIGN_BIT];
   assign expo = i_fp[EXP_MSB:EXP_LSB];
   assign man  = i_fp[MAN_MSB:MAN_LSB];

   // 0.m * 2^e: shift the fraction left by e, then drop the MAN_W fraction
   // bits, which is truncation toward zero on the magnitude.
   assign mag = MAG_W'(({{MAG_W{1'b0}}, man} << expo) >> MAN_W);

   always_comb begin
      o_int = '0;
      uf    = 1'b0;
      of    = 1'b0;
      if (mag == '0) begin
         uf = (man != '0);
      end else if (sign) begin
         // -128 is representable, so only magnitudes above 128 overflow.
         if (mag > MAG_W'(-INT_MIN)) begin
            of    = 1'b1;
            o_int = INT_W'(INT_MIN);
         end else begin
            o_int = INT_W'(MAG_W'(0) - mag);
         end
      end else begin
         if (mag > MAG_W'(INT_MAX)) begin
            of    = 1'b1;
            o_int = INT_W'(INT_MAX);
         end else begin
            o_int = mag[INT_W-1:0];
         end
      end
   end

endmodule

// File: rtl/fp2int_sched.sv
// fp2int_sched: round-robin scheduler sharing one fp_to_int converter.
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   i_req          : per-requester request level
//   i_fp           : flattened operands, requester k at [k*FP_W +: FP_W]
//   o_gnt          : one-hot single-cycle grant (combinational, IDLE only)
//   o_valid/i_ready: result handshake
//   o_id           : requester index of the result
//   o_int/o_uf/o_of: converted integer and its flags
//   o_busy         : high whenever the FSM is not IDLE
// Flow: IDLE (grant + capture) -> CONV (register result) -> OUT (handshake).
module fp2int_sched #(
   parameter int N_REQ = 4,
   parameter int FP_W  = fp2int_pkg::FP_W,
   parameter int INT_W = fp2int_pkg::INT_W,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [N_REQ-1:0]      i_req,
   input  logic [N_REQ*FP_W-1:0] i_fp,
   output logic [N_REQ-1:0]      o_gnt,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [ID_W-1:0]       o_id,
   output logic [INT_W-1:0]      o_int,
   output logic                  o_uf,
   output logic                  o_of,
   output logic                  o_busy
);

   import fp2int_pkg::*;

   state_t           state;
   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  pick;
   logic             pick_any;
   logic [ID_W-1:0]  id_q;
   logic [FP_W-1:0]  op;
   logic [INT_W-1:0] cv_int;
   logic             cv_uf;
   logic             cv_of;

   // Round-robin picker: first active requester at or after ptr, cyclically.
   always_comb begin
      int k;
      k        = 0;
      pick     = '0;
      pick_any = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         k = (int'(ptr) + i) % N_REQ;
         if (!pick_any && i_req[ID_W'(k)]) begin
            pick_any = 1'b1;
            pick     = ID_W'(k);
         end
      end
   end

   // Gated by i_rst_n so no grant can leak out while reset is held.
   assign o_gnt  = (i_rst_n && state == IDLE && pick_any) ? (N_REQ'(1) << pick) : '0;
   assign o_busy = (state != IDLE);

   // Operand/id capture on the grant edge; data path needs no reset.
   always_ff @(posedge i_clk) begin
      if (state == IDLE && pick_any) begin
         op   <= i_fp[pick*FP_W +: FP_W];
         id_q <= pick;
      end
   end

   fp_to_int u_conv (
      .i_fp  (op),
      .o_int (cv_int),
      .uf    (cv_uf),
      .of    (cv_of)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         ptr     <= '0;
         o_valid <= 1'b0;
         o_id    <= '0;
         o_int   <= '0;
         o_uf    <= 1'b0;
         o_of    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  // The winner gets lowest priority in the next round.
                  ptr   <= (pick == ID_W'(N_REQ - 1)) ? '0 : pick + 1'b1;
                  state <= CONV;
               end
            end
            CONV: begin
               o_int   <= cv_int;
               o_uf    <= cv_uf;
               o_of    <= cv_of;
               o_id    <= id_q;
               o_valid <= 1'b1;
               state   <= OUT;
            end
            OUT: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp2int_sched.sv
// tb_fp2int_sched: self-checking bench for fp2int_sched (N_REQ=4).
//   Directed and randomized transactions compared against an arithmetic
//   conversion model and a round-robin pointer model.
module tb_fp2int_sched;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [51:0] fp;
   logic [3:0]  gnt;
   logic        valid;
   logic        ready;
   logic [1:0]  id;
   logic [7:0]  res;
   logic        uf;
   logic        of;
   logic        busy;

   int checks = 0;
   int passed = 0;
   int rr     = 0;

   always #5 clk = ~clk;

   fp2int_sched #(.N_REQ(4), .FP_W(13), .INT_W(8), .ID_W(2)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_req   (req),
      .i_fp    (fp),
      .o_gnt   (gnt),
      .o_valid (valid),
      .i_ready (ready),
      .o_id    (id),
      .o_int   (res),
      .o_uf    (uf),
      .o_of    (of),
      .o_busy  (busy)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // value = (-1)^s * floor(m * 2^e / 256), then saturate to [-128,127].
   function automatic logic [9:0] ref_conv(input logic [12:0] f);
      longint     mag;
      longint     v;
      logic [7:0] r;
      logic       u;
      logic       o;
      mag = (longint'(f[7:0]) << f[11:8]) / 256;
      v   = f[12] ? -mag : mag;
      u   = (f[7:0] != 0) && (mag == 0);
      o   = (v > 127) || (v < -128);
      if (v > 127) v = 127;
      else if (v < -128) v = -128;
      r = v[7:0];
      return {r, u, o};
   endfunction

   function automatic int ref_pick(input logic [3:0] r);
      int k;
      for (int i = 0; i < N; i++) begin
         k = (rr + i) % N;
         if (r[2'(k)]) return k;
      end
      return 0;
   endfunction

   // Called at a negedge in IDLE with req (non-zero) and fp already driven.
   task automatic txn(input int hold);
      int         w;
      logic [9:0] e;
      #1;
      w = ref_pick(req);
      check("valid_idle", 32'(valid), 0);
      check("busy_idle", 32'(busy), 0);
      check("gnt", 32'(gnt), 32'(4'(1) << w));
      e  = ref_conv(fp[w*13 +: 13]);
      rr = (w + 1) % N;
      @(negedge clk); #1;
      check("gnt_conv", 32'(gnt), 0);
      check("valid_conv", 32'(valid), 0);
      check("busy_conv", 32'(busy), 1);
      @(negedge clk); #1;
      check("valid_out", 32'(valid), 1);
      check("id", 32'(id), 32'(w));
      check("int", 32'(res), 32'(e[9:2]));
      check("uf", 32'(uf), 32'(e[1]));
      check("of", 32'(of), 32'(e[0]));
      for (int c = 0; c < hold; c++) begin
         ready = 1'b0;
         @(negedge clk); #1;
         check("hold_valid", 32'(valid), 1);
         check("hold_id", 32'(id), 32'(w));
         check("hold_int", 32'(res), 32'(e[9:2]));
         check("hold_gnt", 32'(gnt), 0);
      end
      ready = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'hF;
      fp    = '0;
      ready = 1'b1;
      #1;
      check("rst_gnt", 32'(gnt), 0);
      check("rst_valid", 32'(valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_id", 32'(id), 0);
      check("rst_int", 32'(res), 0);
      check("rst_uf", 32'(uf), 0);
      check("rst_of", 32'(of), 0);
      @(negedge clk);
      @(negedge clk);
      req   = 4'h0;
      rst_n = 1'b1;
      #1;
      check("rel_gnt", 32'(gnt), 0);
      @(negedge clk);

      // All four requesting continuously: grants 0,1,2,3,0 at 3-cycle spacing.
      fp  = {13'b1100010000000, 13'b0100010000000, 13'b0000011111111, 13'b1000111110000};
      req = 4'hF;
      repeat (5) txn(0);

      // Single request on requester 2, +1.
      req = 4'b0100;
      fp[2*13 +: 13] = 13'b0000110000000;
      txn(0);

      // Negative overflow on requester 1.
      req = 4'b0010;
      fp[1*13 +: 13] = 13'b1111111111111;
      txn(0);

      // +0 and -0.
      req = 4'b0001;
      fp[0*13 +: 13] = 13'b0000000000000;
      txn(0);
      req = 4'b1000;
      fp[3*13 +: 13] = 13'b1000000000000;
      txn(0);

      // No request: stays idle.
      req = 4'b0000;
      #1;
      check("idle_gnt", 32'(gnt), 0);
      @(negedge clk); #1;
      check("idle_gnt2", 32'(gnt), 0);
      check("idle_busy", 32'(busy), 0);
      @(negedge clk);

      // Backpressure with all requesters pending, then immediate next grant.
      req = 4'hF;
      for (int k = 0; k < N; k++) fp[k*13 +: 13] = 13'($urandom);
      txn(5);
      txn(0);

      // Randomized traffic.
      repeat (40) begin
         req = 4'($urandom_range(1, 15));
         for (int k = 0; k < N; k++) fp[k*13 +: 13] = 13'($urandom);
         txn($urandom_range(0, 2));
      end

      // Leave a non-zero result on the outputs before the reset test.
      req = 4'b1000;
      fp[3*13 +: 13] = 13'b0000110000000;
      txn(0);

      // Reset mid-CONV.
      req = 4'b0101;
      fp[0*13 +: 13] = 13'b0000110000000;
      #1;
      check("pre_rst_gnt", 32'(gnt), 32'(4'(1) << ref_pick(req)));
      @(negedge clk); #1;
      check("pre_rst_busy", 32'(busy), 1);
      #1;
      rst_n = 1'b0;
      #1;
      rr = 0;
      check("mid_rst_gnt", 32'(gnt), 0);
      check("mid_rst_valid", 32'(valid), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_id", 32'(id), 0);
      check("mid_rst_int", 32'(res), 0);
      check("mid_rst_flags", 32'({uf, of}), 0);
      @(negedge clk);
      req   = 4'b0000;
      rst_n = 1'b1;
      #1;
      check("post_rel_gnt", 32'(gnt), 0);
      @(negedge clk);
      req = 4'b0101;
      txn(0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
